// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the register-file write port between the WB stage and a long-latency
// unit. Long-unit results are buffered in a small FIFO. Each cycle one source
// is granted the port. WB is stalled when the buffer head must drain first.
// A registered mask of pending FIFO destinations is published to hazard logic.
// Optional feature: define WBARB_PERF_EN to add the StallCnt/LongCnt counters.
module wb_port_arbiter #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 RegwriteW,
   input  logic [ADDR_W-1:0]    WriteregW,
   input  logic [DATA_W-1:0]    ResultW,
   input  logic                 LongValid,
   output logic                 LongReady,
   input  logic [ADDR_W-1:0]    LongWreg,
   input  logic [DATA_W-1:0]    LongData,
   output logic                 RfWe,
   output logic [ADDR_W-1:0]    RfWaddr,
   output logic [DATA_W-1:0]    RfWdata,
   output logic                 StallW,
   output logic [2**ADDR_W-1:0] PendMask
`ifdef WBARB_PERF_EN
   ,
   output logic [31:0]          StallCnt,
   output logic [31:0]          LongCnt
`endif
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
   localparam int unsigned NREG   = 2**ADDR_W;

   localparam logic [CNT_W-1:0]  DEPTH_V    = CNT_W'(DEPTH);
   localparam logic [WAIT_W-1:0] MAX_WAIT_V = WAIT_W'(MAX_WAIT);

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_WB,
      GNT_HEAD,
      GNT_HEAD_STALL
   } gnt_e;

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [ADDR_W-1:0] addr_d [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [NREG-1:0]   pend_q, pend_d;

   logic full, empty, push, wb_req, conflict, force_drain, pop;
   gnt_e gnt;

   assign full        = (cnt_q == DEPTH_V);
   assign empty       = (cnt_q == '0);
   assign LongReady   = !full;
   // Writes to r0 are acknowledged but dropped, so they never enter the FIFO.
   assign push        = LongValid && !full && (LongWreg != '0);
   assign wb_req      = RegwriteW && (WriteregW != '0);
   assign conflict    = wb_req && pend_q[WriteregW];
   assign force_drain = !empty && (wait_q >= MAX_WAIT_V);
   assign pop         = (gnt == GNT_HEAD) || (gnt == GNT_HEAD_STALL);
   assign PendMask    = pend_q;

   // Grant selection: forced/conflict drain, then WB, then opportunistic drain.
   always_comb begin
      gnt = GNT_NONE;
      if (force_drain || conflict) begin
         gnt = GNT_HEAD_STALL;
      end else if (wb_req) begin
         gnt = GNT_WB;
      end else if (!empty) begin
         gnt = GNT_HEAD;
      end
   end

   // Register-file port and WB stall driven from the grant.
   always_comb begin
      RfWe    = 1'b0;
      RfWaddr = '0;
      RfWdata = '0;
      StallW  = 1'b0;
      case (gnt)
         GNT_HEAD_STALL: begin
            RfWe    = 1'b1;
            RfWaddr = addr_q[rd_ptr_q];
            RfWdata = data_q[rd_ptr_q];
            StallW  = 1'b1;
         end
         GNT_WB: begin
            RfWe    = 1'b1;
            RfWaddr = WriteregW;
            RfWdata = ResultW;
         end
         GNT_HEAD: begin
            RfWe    = 1'b1;
            RfWaddr = addr_q[rd_ptr_q];
            RfWdata = data_q[rd_ptr_q];
         end
         default: ;
      endcase
   end

   // FIFO, wait counter and pending-mask next state.
   always_comb begin
      addr_d   = addr_q;
      data_d   = data_q;
      valid_d  = valid_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      wait_d   = wait_q;
      pend_d   = '0;

      if (pop) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
         addr_d[wr_ptr_q]  = LongWreg;
         data_d[wr_ptr_q]  = LongData;
         valid_d[wr_ptr_q] = 1'b1;
         wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end

      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: ;
      endcase

      if (empty || pop) begin
         wait_d = '0;
      end else if (wait_q < MAX_WAIT_V) begin
         wait_d = wait_q + WAIT_W'(1);
      end

      // Mask reflects the entries that will be valid after this edge.
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (valid_d[i]) begin
            pend_d[addr_d[i]] = 1'b1;
         end
      end
   end

   // State registers; reset discards any buffered results.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
         valid_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         wait_q   <= '0;
         pend_q   <= '0;
      end else begin
         addr_q   <= addr_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         wait_q   <= wait_d;
         pend_q   <= pend_d;
      end
   end

`ifdef WBARB_PERF_EN
   logic [31:0] stall_cnt_q, long_cnt_q;

   // Free-running performance counters, wrapping modulo 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         long_cnt_q  <= '0;
      end else begin
         if (StallW) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (pop) begin
            long_cnt_q <= long_cnt_q + 32'd1;
         end
      end
   end

   assign StallCnt = stall_cnt_q;
   assign LongCnt  = long_cnt_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: stimulus queues expected regfile writes
// (cycle, address, data, stall); a negedge monitor pops and compares them.
module tb_wb_port_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          RegwriteW = 1'b0;
   logic [AW-1:0] WriteregW = '0;
   logic [DW-1:0] ResultW = '0;
   logic          LongValid = 1'b0;
   logic          LongReady;
   logic [AW-1:0] LongWreg = '0;
   logic [DW-1:0] LongData = '0;
   logic          RfWe;
   logic [AW-1:0] RfWaddr;
   logic [DW-1:0] RfWdata;
   logic          StallW;
   logic [31:0]   PendMask;

   wb_port_arbiter #(
      .DATA_W  (DW),
      .ADDR_W  (AW),
      .DEPTH   (2),
      .MAX_WAIT(4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .RegwriteW(RegwriteW),
      .WriteregW(WriteregW),
      .ResultW  (ResultW),
      .LongValid(LongValid),
      .LongReady(LongReady),
      .LongWreg (LongWreg),
      .LongData (LongData),
      .RfWe     (RfWe),
      .RfWaddr  (RfWaddr),
      .RfWdata  (RfWdata),
      .StallW   (StallW),
      .PendMask (PendMask)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned   cyc;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          stall;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %h, required %h", name, cyc, act, req);
      end
   endtask

   task automatic drive(input logic rw, input logic [AW-1:0] wr, input logic [DW-1:0] res,
                        input logic lv, input logic [AW-1:0] lwr, input logic [DW-1:0] ld);
      RegwriteW = rw;
      WriteregW = wr;
      ResultW   = res;
      LongValid = lv;
      LongWreg  = lwr;
      LongData  = ld;
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic s);
      exp_t e;
      e.cyc   = cyc;
      e.addr  = a;
      e.data  = d;
      e.stall = s;
      exp_q.push_back(e);
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // Monitor: every regfile write must match the oldest expectation for this cycle.
   always @(negedge clk) begin
      exp_t e;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         e = exp_q.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL missed_write: exp cyc %0d r%0d=%h never written", e.cyc, e.addr, e.data);
      end
      if (RfWe) begin
         if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write @cyc %0d: got r%0d=%h stall=%b, required no write",
                     cyc, RfWaddr, RfWdata, StallW);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr",  32'(RfWaddr), 32'(e.addr));
            chk("wr_data",  RfWdata,      e.data);
            chk("wr_stall", 32'(StallW),  32'(e.stall));
         end
      end else begin
         chk("stall_without_write", 32'(StallW), 32'd0);
      end
   end

   initial begin
      // Reset state
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      mid();
      chk("rst_LongReady", 32'(LongReady), 32'd1);
      chk("rst_StallW",    32'(StallW),    32'd0);
      chk("rst_RfWe",      32'(RfWe),      32'd0);
      chk("rst_PendMask",  PendMask,       32'd0);
      next();
      rst = 1'b0;
      next();

      // 1: reset mid-stream with two buffered entries
      drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd9, 32'h90);
      exp_wr(5'd5, 32'h11, 1'b0);
      next();
      drive(1'b1, 5'd5, 32'h12, 1'b1, 5'd10, 32'hA0);
      exp_wr(5'd5, 32'h12, 1'b0);
      mid();
      chk("t1_LongReady_one", 32'(LongReady), 32'd1);
      chk("t1_PendMask_one",  PendMask,       32'h0000_0200);
      next();
      chk("t1_LongReady_full", 32'(LongReady), 32'd0);
      chk("t1_PendMask_full",  PendMask,       32'h0000_0600);
      idle();
      rst = 1'b1;
      #1;
      chk("t1_rst_LongReady", 32'(LongReady), 32'd1);
      chk("t1_rst_PendMask",  PendMask,       32'd0);
      mid();
      chk("t1_rst_RfWe", 32'(RfWe), 32'd0);
      next();
      rst = 1'b0;
      mid();
      chk("t1_post_RfWe",      32'(RfWe),      32'd0);
      chk("t1_post_PendMask",  PendMask,       32'd0);
      chk("t1_post_LongReady", 32'(LongReady), 32'd1);
      next();
      next();

      // 2: continuous WB r5; one long result r9 drains after MAX_WAIT cycles
      drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd9, 32'hAB);
      exp_wr(5'd5, 32'h11, 1'b0);
      next();
      for (int k = 1; k <= 4; k++) begin
         drive(1'b1, 5'd5, 32'h11, 1'b0, '0, '0);
         exp_wr(5'd5, 32'h11, 1'b0);
         if (k == 1) begin
            mid();
            chk("t2_PendMask_r9", PendMask, 32'h0000_0200);
         end
         next();
      end
      exp_wr(5'd9, 32'hAB, 1'b1);
      next();
      exp_wr(5'd5, 32'h11, 1'b0);
      mid();
      chk("t2_PendMask_clear", PendMask, 32'd0);
      next();
      idle();
      next();

      // 3: WAW conflict: older long r7 must land before the WB r7 write
      drive(1'b0, '0, '0, 1'b1, 5'd7, 32'h1);
      next();
      drive(1'b1, 5'd7, 32'h2, 1'b0, '0, '0);
      exp_wr(5'd7, 32'h1, 1'b1);
      mid();
      chk("t3_PendMask_r7", PendMask, 32'h0000_0080);
      next();
      exp_wr(5'd7, 32'h2, 1'b0);
      mid();
      chk("t3_PendMask_clear", PendMask, 32'd0);
      next();
      idle();
      next();

      // 4: back-to-back long results, no WB traffic
      drive(1'b0, '0, '0, 1'b1, 5'd1, 32'h101);
      mid();
      chk("t4_LongReady_0", 32'(LongReady), 32'd1);
      next();
      for (int k = 2; k <= 4; k++) begin
         drive(1'b0, '0, '0, 1'b1, 5'(k), 32'h100 + 32'(k));
         exp_wr(5'(k - 1), 32'h100 + 32'(k - 1), 1'b0);
         mid();
         chk("t4_LongReady", 32'(LongReady), 32'd1);
         next();
      end
      idle();
      exp_wr(5'd4, 32'h104, 1'b0);
      mid();
      chk("t4_LongReady_last", 32'(LongReady), 32'd1);
      next();
      next();

      // 5: FIFO fills under WB load; third result waits for a forced pop
      drive(1'b1, 5'd5, 32'h50, 1'b1, 5'd11, 32'hB1);
      exp_wr(5'd5, 32'h50, 1'b0);
      next();
      drive(1'b1, 5'd5, 32'h51, 1'b1, 5'd12, 32'hB2);
      exp_wr(5'd5, 32'h51, 1'b0);
      mid();
      chk("t5_LongReady_c1", 32'(LongReady), 32'd1);
      next();
      for (int k = 2; k <= 4; k++) begin
         drive(1'b1, 5'd5, 32'h50 + 32'(k), 1'b1, 5'd13, 32'hB3);
         exp_wr(5'd5, 32'h50 + 32'(k), 1'b0);
         mid();
         chk("t5_LongReady_full", 32'(LongReady), 32'd0);
         if (k == 2) chk("t5_PendMask_full", PendMask, 32'h0000_1800);
         next();
      end
      drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd13, 32'hB3);
      exp_wr(5'd11, 32'hB1, 1'b1);
      mid();
      chk("t5_LongReady_force", 32'(LongReady), 32'd0);
      next();
      exp_wr(5'd5, 32'h55, 1'b0);
      mid();
      chk("t5_LongReady_after", 32'(LongReady), 32'd1);
      chk("t5_PendMask_after",  PendMask,       32'h0000_1000);
      next();
      idle();
      exp_wr(5'd12, 32'hB2, 1'b0);
      mid();
      chk("t5_PendMask_two", PendMask, 32'h0000_3000);
      next();
      exp_wr(5'd13, 32'hB3, 1'b0);
      next();
      next();

      // 6: r0 is never written, neither from WB nor from the long unit
      drive(1'b1, 5'd0, 32'h55, 1'b0, '0, '0);
      mid();
      chk("t6_wb_r0_RfWe",   32'(RfWe),   32'd0);
      chk("t6_wb_r0_StallW", 32'(StallW), 32'd0);
      next();
      drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h99);
      mid();
      chk("t6_long_r0_LongReady", 32'(LongReady), 32'd1);
      next();
      idle();
      mid();
      chk("t6_PendMask_r0",  PendMask, 32'd0);
      chk("t6_long_r0_RfWe", 32'(RfWe), 32'd0);
      next();
      mid();
      chk("t6_long_r0_RfWe2", 32'(RfWe), 32'd0);
      next();

      repeat (3) next();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
